// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU/RAM types
// Purpose: word type, RAM handshake state and RAM arbiter FSM states.
// Ports: none (package).
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE,
    BUSY,
    ACCESS,
    ERROR
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE,
    XFER0,
    XFER1
  } arb_state_t;

endpackage

// File: rtl/ram_rr_arbiter_rr_pick.sv
// rtl/ram_rr_arbiter_rr_pick.sv - round-robin priority encoder
// Purpose: returns the first set bit of req scanning ptr, ptr+1, ... modulo N.
// Ports:
//   req   in  N       request vector
//   ptr   in  log2(N) scan start (must be < N)
//   valid out 1       at least one request set
//   idx   out log2(N) chosen requester (0 when !valid)
module rr_pick #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  int j;

  // Scan from the farthest offset down to ptr so the closest hit is written last.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    j     = 0;
    for (int i = N - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (req[IW'(j)]) begin
        valid = 1'b1;
        idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/ram_rr_arbiter.sv
// rtl/ram_rr_arbiter.sv - round-robin arbiter sharing one RAM port
// Purpose: grants the RAM port to one of NREQ cache ports at a time and
// sequences single-word or two-word transfers, aborting on ERROR or timeout.
// Ports:
//   CLK, RST                      clock, synchronous active-high reset
//   req_ren/req_wen/req_burst     per-requester read/write/two-word request
//   req_addr/req_store            per-requester byte address / write data
//   req_wait                      per-requester, low only on the acked cycle
//   req_load                      ramload forwarded
//   req_err                       per-requester one-cycle abort pulse
//   ramaddr/ramstore/ramREN/ramWEN RAM command side
//   ramstate/ramload              RAM response side
//   grant_id                      current owner
module ram_rr_arbiter
  import cpu_types_pkg::*;
#(
  parameter  int NREQ    = 4,
  parameter  int TIMEOUT = 255,
  parameter  int CW      = 8,
  localparam int IW      = $clog2(NREQ)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NREQ-1:0]       req_ren,
  input  logic [NREQ-1:0]       req_wen,
  input  logic [NREQ-1:0]       req_burst,
  input  logic [NREQ-1:0][31:0] req_addr,
  input  logic [NREQ-1:0][31:0] req_store,
  output logic [NREQ-1:0]       req_wait,
  output word_t                 req_load,
  output logic [NREQ-1:0]       req_err,
  output word_t                 ramaddr,
  output word_t                 ramstore,
  output logic                  ramREN,
  output logic                  ramWEN,
  input  ramstate_t             ramstate,
  input  word_t                 ramload,
  output logic [IW-1:0]         grant_id
);

  localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

  arb_state_t      state, state_n;
  logic [IW-1:0]   rr_ptr, rr_ptr_n;
  logic [IW-1:0]   grant, grant_n;
  word_t           base_addr, base_addr_n;
  logic            is_write, is_write_n;
  logic [CW-1:0]   wdog, wdog_n;
  logic [NREQ-1:0] req_any;
  logic            pick_valid;
  logic [IW-1:0]   pick_idx;

  assign req_any  = req_ren | req_wen;
  assign req_load = ramload;
  assign grant_id = grant;

  rr_pick #(.N(NREQ)) u_pick (
    .req   (req_any),
    .ptr   (rr_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  function automatic logic [IW-1:0] inc_idx(input logic [IW-1:0] i);
    if (int'(i) == NREQ - 1) return '0;
    return i + 1'b1;
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant     <= '0;
      base_addr <= '0;
      is_write  <= 1'b0;
      wdog      <= '0;
    end else begin
      state     <= state_n;
      rr_ptr    <= rr_ptr_n;
      grant     <= grant_n;
      base_addr <= base_addr_n;
      is_write  <= is_write_n;
      wdog      <= wdog_n;
    end
  end

  always_comb begin
    state_n     = state;
    rr_ptr_n    = rr_ptr;
    grant_n     = grant;
    base_addr_n = base_addr;
    is_write_n  = is_write;
    wdog_n      = wdog;
    req_wait    = '1;
    req_err     = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          grant_n     = pick_idx;
          base_addr_n = req_addr[pick_idx];
          is_write_n  = req_wen[pick_idx];  // write wins over a simultaneous read
          wdog_n      = '0;
          state_n     = XFER0;
        end
      end
      XFER0, XFER1: begin
        ramaddr  = (state == XFER1) ? base_addr + 32'd4 : base_addr;
        ramstore = req_store[grant];
        if (!req_any[grant]) begin
          // Requester withdrew: release the port quietly, no ack and no error.
          state_n  = IDLE;
          rr_ptr_n = inc_idx(grant);
        end else begin
          ramWEN = is_write;
          ramREN = !is_write;
          if (ramstate == ACCESS) begin
            req_wait[grant] = 1'b0;
            if (state == XFER0 && req_burst[grant]) begin
              state_n = XFER1;
              wdog_n  = '0;
            end else begin
              state_n  = IDLE;
              rr_ptr_n = inc_idx(grant);
            end
          end else if (ramstate == ERROR || wdog == TMO) begin
            req_err[grant] = 1'b1;
            state_n        = IDLE;
            rr_ptr_n       = inc_idx(grant);
          end else begin
            // wdog < TMO here, so this saturates at TIMEOUT.
            wdog_n = wdog + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// tb/tb_ram_rr_arbiter.sv - directed self-checking bench for ram_rr_arbiter
module tb_ram_rr_arbiter;
  import cpu_types_pkg::*;

  localparam int NREQ = 4;

  logic                  CLK = 1'b0;
  logic                  RST;
  logic [NREQ-1:0]       req_ren, req_wen, req_burst;
  logic [NREQ-1:0][31:0] req_addr, req_store;
  logic [NREQ-1:0]       req_wait, req_err;
  word_t                 req_load, ramaddr, ramstore, ramload;
  logic                  ramREN, ramWEN;
  ramstate_t             ramstate;
  logic [1:0]            grant_id;

  int total = 0;
  int bad   = 0;

  ram_rr_arbiter #(.NREQ(NREQ), .TIMEOUT(4), .CW(4)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .req_ren   (req_ren),
    .req_wen   (req_wen),
    .req_burst (req_burst),
    .req_addr  (req_addr),
    .req_store (req_store),
    .req_wait  (req_wait),
    .req_load  (req_load),
    .req_err   (req_err),
    .ramaddr   (ramaddr),
    .ramstore  (ramstore),
    .ramREN    (ramREN),
    .ramWEN    (ramWEN),
    .ramstate  (ramstate),
    .ramload   (ramload),
    .grant_id  (grant_id)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic cyc;
    @(posedge CLK);
    #1;
  endtask

  // Let combinational outputs settle mid-cycle before sampling.
  task automatic settle;
    #2;
  endtask

  initial begin
    RST       = 1'b1;
    req_ren   = '0;
    req_wen   = '0;
    req_burst = '0;
    req_addr  = '0;
    req_store = '0;
    ramstate  = FREE;
    ramload   = '0;
    cyc; cyc;
    settle;
    check("rst_wait",  32'(req_wait), 32'hF);
    check("rst_err",   32'(req_err),  32'h0);
    check("rst_ren",   32'(ramREN),   32'h0);
    check("rst_wen",   32'(ramWEN),   32'h0);
    check("rst_addr",  ramaddr,       32'h0);
    check("rst_store", ramstore,      32'h0);
    check("rst_gid",   32'(grant_id), 32'h0);
    RST = 1'b0;

    // Single-word read by requester 2, ACCESS on second XFER0 cycle.
    cyc;
    req_ren     = 4'b0100;
    req_addr[2] = 32'h0000_0100;
    ramstate    = BUSY;
    settle;
    check("rd_arb_ren",  32'(ramREN),   32'h0);
    check("rd_arb_wait", 32'(req_wait), 32'hF);
    cyc; settle;
    check("rd_x0_ren",  32'(ramREN),   32'h1);
    check("rd_x0_wen",  32'(ramWEN),   32'h0);
    check("rd_x0_addr", ramaddr,       32'h0000_0100);
    check("rd_x0_gid",  32'(grant_id), 32'h2);
    check("rd_x0_wait", 32'(req_wait), 32'hF);
    cyc;
    ramstate = ACCESS;
    ramload  = 32'hDEAD_BEEF;
    settle;
    check("rd_ack_wait", 32'(req_wait), 32'hB);
    check("rd_ack_load", req_load,      32'hDEAD_BEEF);
    cyc;
    req_ren  = '0;
    ramstate = FREE;
    settle;
    check("rd_idle_wait", 32'(req_wait), 32'hF);
    check("rd_idle_ren",  32'(ramREN),   32'h0);

    // rr_ptr is now 3: requesters 1 and 3 compete, 3 must win.
    cyc;
    req_ren  = 4'b1010;
    ramstate = ACCESS;
    cyc; settle;
    check("ptr3_gid",  32'(grant_id), 32'h3);
    check("ptr3_wait", 32'(req_wait), 32'h7);
    cyc;
    req_ren = '0;

    // Contention from rr_ptr=0: all four request, immediate ACCESS.
    cyc;
    req_ren = 4'hF;
    settle;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("ct_idle%0d", k), 32'(req_wait), 32'hF);
      cyc; settle;
      check($sformatf("ct_gid%0d", k),  32'(grant_id), 32'(k % 4));
      check($sformatf("ct_wait%0d", k), 32'(req_wait), 32'(~(4'b1 << (k % 4)) & 4'hF));
      cyc; settle;
    end
    req_ren  = '0;
    ramstate = FREE;

    // Burst write by requester 1 (rr_ptr=1) across the 32-bit wrap.
    cyc;
    req_wen      = 4'b0010;
    req_burst    = 4'b0010;
    req_addr[1]  = 32'hFFFF_FFFC;
    req_store[1] = 32'h1111_1111;
    ramstate     = BUSY;
    cyc;
    ramstate = ACCESS;
    settle;
    check("bw_x0_wen",   32'(ramWEN),   32'h1);
    check("bw_x0_ren",   32'(ramREN),   32'h0);
    check("bw_x0_addr",  ramaddr,       32'hFFFF_FFFC);
    check("bw_x0_store", ramstore,      32'h1111_1111);
    check("bw_x0_wait",  32'(req_wait), 32'hD);
    cyc;
    req_store[1] = 32'h2222_2222;
    ramstate     = BUSY;
    settle;
    check("bw_x1_addr",  ramaddr,       32'h0000_0000);
    check("bw_x1_store", ramstore,      32'h2222_2222);
    check("bw_x1_wen",   32'(ramWEN),   32'h1);
    check("bw_x1_wait",  32'(req_wait), 32'hF);
    cyc;
    ramstate = ACCESS;
    settle;
    check("bw_ack2_wait", 32'(req_wait), 32'hD);
    check("bw_ack2_addr", ramaddr,       32'h0000_0000);
    cyc;
    req_wen   = '0;
    req_burst = '0;
    ramstate  = FREE;
    settle;
    check("bw_idle_wen",  32'(ramWEN),   32'h0);
    check("bw_idle_wait", 32'(req_wait), 32'hF);

    // ERROR in XFER1 of requester 2's burst (rr_ptr=2), requester 0 waiting.
    cyc;
    req_ren   = 4'b0101;
    req_burst = 4'b0100;
    ramstate  = ACCESS;
    cyc; settle;
    check("er_x0_gid",  32'(grant_id), 32'h2);
    check("er_x0_wait", 32'(req_wait), 32'hB);
    cyc;
    ramstate = ERROR;
    settle;
    check("er_x1_err",  32'(req_err),  32'h4);
    check("er_x1_wait", 32'(req_wait), 32'hF);
    cyc;
    ramstate = ACCESS;
    settle;
    check("er_idle_err",  32'(req_err),  32'h0);
    check("er_idle_wait", 32'(req_wait), 32'hF);
    check("er_idle_ren",  32'(ramREN),   32'h0);
    cyc; settle;
    check("er_next_gid",  32'(grant_id), 32'h0);
    check("er_next_wait", 32'(req_wait), 32'hE);
    cyc;
    req_ren   = '0;
    req_burst = '0;
    ramstate  = FREE;

    // Watchdog: requester 1 (rr_ptr=1) held BUSY, TIMEOUT=4.
    cyc;
    req_ren  = 4'b0010;
    ramstate = BUSY;
    for (int k = 1; k <= 4; k++) begin
      cyc; settle;
      check($sformatf("to_c%0d_err", k), 32'(req_err), 32'h0);
      check($sformatf("to_c%0d_ren", k), 32'(ramREN),  32'h1);
    end
    cyc; settle;
    check("to_c5_err",  32'(req_err),  32'h2);
    check("to_c5_wait", 32'(req_wait), 32'hF);
    cyc;
    req_ren = '0;
    settle;
    check("to_after_ren", 32'(ramREN),  32'h0);
    check("to_after_err", 32'(req_err), 32'h0);

    // Drop: requester 3 (rr_ptr=2) withdraws during XFER0.
    cyc;
    req_ren = 4'b1000;
    cyc; settle;
    check("dr_x0_gid", 32'(grant_id), 32'h3);
    check("dr_x0_ren", 32'(ramREN),   32'h1);
    cyc;
    req_ren  = '0;
    ramstate = ACCESS;
    settle;
    check("dr_ren",  32'(ramREN),   32'h0);
    check("dr_wait", 32'(req_wait), 32'hF);
    check("dr_err",  32'(req_err),  32'h0);
    cyc; settle;
    check("dr_idle_ren", 32'(ramREN), 32'h0);

    // Reset during XFER1 of requester 0 (rr_ptr=0).
    req_ren     = 4'b0001;
    req_burst   = 4'b0001;
    req_addr[0] = 32'h0000_0200;
    cyc; settle;
    check("rs_x0_wait", 32'(req_wait), 32'hE);
    cyc;
    ramstate = BUSY;
    settle;
    check("rs_x1_addr", ramaddr,      32'h0000_0204);
    check("rs_x1_ren",  32'(ramREN),  32'h1);
    check("rs_x1_err",  32'(req_err), 32'h0);
    RST = 1'b1;
    cyc; settle;
    check("rs_wait", 32'(req_wait), 32'hF);
    check("rs_err",  32'(req_err),  32'h0);
    check("rs_ren",  32'(ramREN),   32'h0);
    check("rs_wen",  32'(ramWEN),   32'h0);
    check("rs_addr", ramaddr,       32'h0);
    check("rs_gid",  32'(grant_id), 32'h0);
    RST       = 1'b0;
    req_ren   = '0;
    req_burst = '0;
    cyc;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_rr_arbiter.md
Name: ram_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the single RAM port among NREQ requesters (icache/dcache ports of each core).
- Sits between the caches and the RAM model. Serializes single-word and two-word burst transfers.
- Tracks ramstate and aborts a transfer on ERROR or on watchdog timeout.

Parameters:
NREQ, 4, number of requesters (2..8)
TIMEOUT, 255, max cycles in a transfer state without ACCESS before abort
CW, 8, watchdog counter width (must satisfy 2**CW > TIMEOUT)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset (see Interface)
req_ren  in  NREQ  per-requester read request
req_wen  in  NREQ  per-requester write request
req_burst  in  NREQ  1 = two-word transfer, 0 = single word
req_addr  in  NREQ x 32  byte address (word_t)
req_store  in  NREQ x 32  write data
req_wait  out  NREQ  low for exactly the ACCESS cycle of the granted word
req_load  out  32  ramload forwarded (valid when req_wait[g]=0)
req_err  out  NREQ  one-cycle pulse on abort of the granted requester
ramaddr  out  32  RAM address
ramstore  out  32  RAM write data
ramREN  out  1  RAM read enable
ramWEN  out  1  RAM write enable
ramstate  in  ramstate_t  FREE/BUSY/ACCESS/ERROR
ramload  in  32  RAM read data
grant_id  out  $clog2(NREQ)  current owner, debug/snoop visibility

Behaviour:
Interface:
- One clock, CLK. Reset RST is synchronous and active-high.
- Reset values: state=IDLE, rr_ptr=0, grant=0, base_addr=0, wdog=0. All outputs inactive: req_wait all 1, req_err 0, ramREN/ramWEN 0, ramaddr/ramstore 0.
- RST asserted mid-transfer abandons the transfer silently. No req_err pulse.

States: IDLE, XFER0, XFER1.

IDLE:
- Pick the first requester with ren|wen, scanning rr_ptr, rr_ptr+1, ... modulo NREQ.
- Register grant, latch base_addr=req_addr[g] and is_write=req_wen[g], clear wdog, go to XFER0. No requester: stay in IDLE.
- Minimum one arbitration cycle. Earliest ack is the cycle after the request is first seen.

XFER0 / XFER1:
- ramaddr = base_addr (XFER0) or base_addr+4 (XFER1), modulo 2^32 with wrap.
- ramWEN = is_write. ramREN = !is_write.
- ramstore = req_store[g] (live; requester presents word 2 after the first ack).
- If the same requester asserts ren and wen together at grant, write wins.
- req_load = ramload, combinational.
- On ramstate==ACCESS: req_wait[g]=0 in that same cycle.
  - XFER0 with req_burst[g]: go to XFER1 and clear wdog.
  - Otherwise: go to IDLE, rr_ptr = g+1 mod NREQ.
- On ramstate==ERROR, or wdog==TIMEOUT: req_err[g]=1 for one cycle, req_wait[g] stays 1, go to IDLE, rr_ptr = g+1.
- If req_ren[g]|req_wen[g] drops while in XFER0/XFER1: go to IDLE immediately, RAM enables 0 that cycle, no ack, no err, rr_ptr = g+1.
- wdog increments every transfer cycle that is not ACCESS, saturating at TIMEOUT.

General rules:
- Grant is locked for the whole burst. No preemption.
- Non-granted requesters always see req_wait=1.
- A requester re-requesting immediately after completion is scanned last (fairness).
- The first ACCESS seen one cycle after grant is legal and is acked.

Decomposition:
- cpu_types_pkg already provides word_t and ramstate_t.
- Add to it: typedef enum logic [1:0] arb_state_t {IDLE, XFER0, XFER1}.
- Sub-module rr_pick: combinational priority encoder. Inputs: request vector, rr_ptr. Outputs: valid, index. Reused by later coherence arbitration.

Test Plan:
- Single word read: req_ren[2]=1, addr 0x100, ramstate ACCESS on 2nd cycle of XFER0 -> req_wait[2]=0 one cycle, req_load=ramload, rr_ptr=3, IDLE.
- Burst write: req_wen[1]=1, burst=1, addr 0xFFFFFFFC -> ramaddr 0xFFFFFFFC then 0x00000000; two acks; ramstore follows req_store.
- Contention: all four requesting continuously, single words, immediate ACCESS -> grants 0,1,2,3,0 in order; no requester granted twice before the others.
- ERROR: ramstate=ERROR in XFER1 -> req_err[g] one-cycle pulse, no second ack, IDLE next cycle, grant advances.
- Timeout: ramstate held BUSY with TIMEOUT=4 -> req_err pulses after the 5th transfer cycle; ramREN low afterwards.
- Requester drop and reset: req_ren dropped in XFER0 -> IDLE with no ack or err. RST asserted in XFER1 -> all outputs at reset values on the next edge.
